shift_register_n: RTL
=====================

SHIFT_REGISTER_N -- requirements
Module: shift_register_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2 to 64).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the width of the counted-operation repeat count.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port en  input  1  direct-mode operation enable.
REQ-006 The block SHALL have port s  input  3  mode select, encoded per REQ-015.
REQ-007 The block SHALL have port dsl  input  1  serial input shifted into bit 0 on left shift.
REQ-008 The block SHALL have port dsr  input  1  serial input shifted into bit WIDTH-1 on right shift.
REQ-009 The block SHALL have port din  input  WIDTH  parallel load data.
REQ-010 The block SHALL have port cnt  input  CNT_W  repeat count for a counted operation.
REQ-011 The block SHALL have port start  input  1  request to begin a counted operation.
REQ-012 The block SHALL have port q  output  WIDTH  register contents.
REQ-013 The block SHALL have ports sout_l and sout_r, each output 1, driven combinationally as q[WIDTH-1] and q[0].
REQ-014 The block SHALL have ports busy and done, each output 1, giving counted-operation status.

Function
REQ-015 Mode s SHALL select one of eight operations:
- 000: hold.
- 001: shift right, q <= {dsr, q[W-1:1]}.
- 010: shift left, q <= {q[W-2:0], dsl}.
- 011: parallel load, q <= din.
- 100: rotate right, q <= {q[0], q[W-1:1]}.
- 101: rotate left, q <= {q[W-2:0], q[W-1]}.
- 110: arithmetic right, q <= {q[W-1], q[W-1:1]}.
- 111: reserved, behaves as hold.
REQ-016 The control FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE with start=0, the block SHALL apply the op selected by s at each edge where en=1, and SHALL hold q when en=0.
REQ-018 In IDLE with start=1, the block SHALL:
- latch s into op_r and cnt into rem, perform no op on that edge, and ignore en;
- go to RUN if cnt is nonzero;
- go directly to DONE if cnt=0, leaving q unchanged.
REQ-019 In RUN, each edge SHALL apply op_r once and decrement rem; on the edge where rem goes 1 to 0, the FSM SHALL enter DONE.
REQ-020 The latency rule SHALL be: for cnt=N>0, busy is high for exactly N cycles, q changes N times, and done is high in cycle N+1 after the start edge.
REQ-021 A counted parallel load (op_r=011) SHALL reload din, sampled each RUN edge, once per repeat.
REQ-022 During RUN and DONE, s, en, cnt and start SHALL be ignored, and start SHALL NOT be queued.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE with no op on the exiting edge.
REQ-024 busy SHALL be 1 exactly when state is RUN.
REQ-025 cnt values up to 2^CNT_W-1 SHALL be honoured; rotates with cnt of WIDTH or more SHALL wrap naturally.
REQ-026 dsl and dsr SHALL be sampled on every edge at which a shift using them occurs, including during RUN.

Reset
REQ-027 rst=1 at an edge SHALL force q=0, state IDLE, rem=0, op_r=000, busy=0 and done=0, with priority over all other inputs.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-029 All outputs SHALL be defined from the first edge with rst=1, and no asynchronous reset path SHALL exist.

Verification (WIDTH=8, CNT_W=4)
REQ-030 Directed load: rst, then s=011, din=B5, en=1 for 1 edge -> q=B5, sout_l=1, sout_r=1.
REQ-031 Directed shift right: q=B5, s=001, dsr=1, en=1 for 2 edges -> q=DA then ED; with en=0 a third edge -> q stays ED.
REQ-032 Counted rotate left: q=81, start=1, s=101, cnt=3 -> busy=1 for 3 cycles with q=03, 06, 0C, then done=1 for 1 cycle, then IDLE.
REQ-033 Counted arithmetic right: q=90, start=1, s=110, cnt=2 -> q=C8 then E4, done pulse; start pulses during busy are ignored.
REQ-034 Zero count: start=1, cnt=0, any s -> busy never asserts, done=1 in the next cycle, q unchanged.
REQ-035 Reset mid-operation: start a cnt=5 shift left and assert rst on the 2nd RUN edge -> q=00, busy=0, and done stays 0 thereafter.

Source files
------------

// File: rtl/shift_register_n.sv
// Universal N-bit shift register with direct and counted operation modes.
// A counted operation repeats one latched op a given number of times, then pulses done.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       s,
  input  logic             dsl,
  input  logic             dsr,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] cnt,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             busy_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] d
  );
    case (op)
      OP_SHR:  apply_op = {sr, cur[WIDTH-1:1]};
      OP_SHL:  apply_op = {cur[WIDTH-2:0], sl};
      OP_LOAD: apply_op = d;
      OP_ROR:  apply_op = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  apply_op = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: apply_op = cur;
    endcase
  endfunction

  // A start request consumes its edge without touching q; DONE likewise exits without an op.
  always_comb begin
    q_d = q_q;
    case (state_q)
      IDLE: if (!start && en) q_d = apply_op(s, q_q, dsl, dsr, din);
      RUN:  q_d = apply_op(op_q, q_q, dsl, dsr, din);
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      op_q    <= OP_HOLD;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q <= q_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= s;
            rem_q <= cnt;
            if (cnt != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // rem_q is never zero here, so the last repeat is the one seeing rem_q == 1
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
